ram_copy_engine: RTL and testbench
==================================

# ram_copy_engine

Initiator-side engine for the single-port word RAM: on a start pulse it copies `len_i` 32-bit words from a source byte address to a destination byte address by driving the RAM's address/enable/write-enable/data port and consuming its one-cycle registered read data. It sits between a control master (core CSR or debug module) and a RAM instance. It owns the RAM port exclusively while busy.

## Interface
Parameters:
- `LEN_W`, 16, width of word-count input; max transfer 2^LEN_W-1 words

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rstn_i`  in  1  asynchronous active-low reset
- `start_i`  in  1  start request, sampled only in IDLE
- `src_i`  in  32  source byte address, latched at start
- `dst_i`  in  32  destination byte address, latched at start
- `len_i`  in  LEN_W  word count, latched at start
- `busy_o`  out  1  high while a copy is in progress
- `done_o`  out  1  one-cycle completion pulse
- `err_o`  out  1  one-cycle error pulse, coincident with `done_o`
- `ram_addr_o`  out  32  RAM byte address (word index = bits 31:2)
- `ram_en_o`  out  1  RAM enable
- `ram_we_o`  out  4  RAM write enables; 4'hF on writes, 4'h0 otherwise
- `ram_din_o`  out  32  RAM write data
- `ram_dout_i`  in  32  RAM read data, valid the cycle after the address is presented

## Operation
- FSM states: IDLE, RD, LAT, WR, DONE. All outputs decoded from registered state/datapath (Moore).
- IDLE: `start_i`=1 latches src/dst/len into `src_q`/`dst_q`/`cnt_q`. If `src_i[1:0]`≠0 or `dst_i[1:0]`≠0 -> DONE with error flag set. Else if `len_i`=0 -> DONE. Else -> RD.
- RD: `ram_en_o`=1, `ram_we_o`=0, `ram_addr_o`=`src_q`. -> LAT.
- LAT: RAM port idle (en=0, we=0); capture `ram_dout_i` into `data_q`. -> WR.
- WR: `ram_en_o`=1, `ram_we_o`=4'hF, `ram_addr_o`=`dst_q`, `ram_din_o`=`data_q`. `src_q`+=4, `dst_q`+=4, `cnt_q`-=1. If `cnt_q` was 1 -> DONE, else -> RD.
- DONE: `done_o`=1, `err_o`=error flag, `busy_o`=0; error flag cleared. -> IDLE.
- `busy_o`=1 in RD, LAT, WR only.
- Address arithmetic is 32-bit modulo: 0xFFFF_FFFC + 4 wraps to 0x0000_0000.
- Copy is strictly ascending, one word at a time; overlapping regions are defined by that order (dst = src+4 replicates the first word).
- `start_i` outside IDLE is ignored; no queuing.
- `ram_din_o` outside WR holds `data_q`; `ram_addr_o` outside RD/WR is 0.

## Timing
- Reset (async, any state): state=IDLE; `busy_o`, `done_o`, `err_o`, `ram_en_o`=0; `ram_we_o`=4'h0; `ram_addr_o`, `ram_din_o`, `data_q`, counters = 0. Reset mid-copy aborts with no done pulse; words already written stay written.
- Start sampled at edge E0: RD during cycle after E0; first write in cycle 3 after E0; N words take 3N cycles of busy; `done_o` high in cycle 3N+1.
- len=0 or misaligned: `done_o` (and `err_o` if misaligned) high in cycle 1 after E0; no RAM access ever asserted.
- Throughput: one word per 3 cycles; `busy_o` drops the same edge `done_o` rises.
- Next start accepted no earlier than the cycle after DONE (IDLE).

## Structure
- Package `ram_copy_pkg`: state enum `copy_state_e` (IDLE, RD, LAT, WR, DONE), constant `WE_FULL`=4'hF, `WE_NONE`=4'h0.
- Single flat module; no sub-module. Bench instantiates engine plus the existing RAM (SIZE ≥ 1024).

## Test plan
- Preload RAM[0x100..0x10C] = 0xA0..0xA3; start src=0x100 dst=0x200 len=4 -> busy 12 cycles, done in cycle 13, RAM[0x200..0x20C] = 0xA0..0xA3, source unchanged, err=0.
- len=0, src=0x100 dst=0x200 -> done+no err in cycle 1, `ram_en_o` never high.
- src=0x102 len=4 -> done and err both pulse in cycle 1, no RAM access; repeat with dst=0x201, same result.
- Start len=4, pulse `start_i` again in cycle 5 with dst=0x300 -> ignored, only 0x200 region written, one done pulse.
- Start len=8, deassert `rstn_i` in cycle 7 -> all outputs 0 immediately, no done; exactly 2 destination words written; fresh start afterwards completes normally.
- RAM[0x100]=0x11, [0x104]=0x22; src=0x100 dst=0x104 len=2 -> RAM[0x104]=0x11, RAM[0x108]=0x11 (ascending-order overlap).

Source files
------------

// File: rtl/ram_copy_pkg.sv
// Shared types and constants for the RAM copy engine.
package ram_copy_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WE_W   = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        LAT  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } copy_state_e;

    localparam logic [WE_W-1:0] WE_FULL = 4'hF;
    localparam logic [WE_W-1:0] WE_NONE = 4'h0;

    localparam logic [ADDR_W-1:0] WORD_BYTES = 32'd4;

    // Word-aligned byte address check.
    function automatic logic is_aligned(input logic [ADDR_W-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage : ram_copy_pkg

// File: rtl/ram_copy_engine.sv
// Word-by-word RAM copy engine: read, wait one cycle for registered data, write.
// Owns the single RAM port while busy; all outputs come straight from flops.
module ram_copy_engine
    import ram_copy_pkg::*;
#(
    parameter int unsigned LEN_W = 16
) (
    input  logic              clk,
    input  logic              rstn_i,
    input  logic              start_i,
    input  logic [31:0]       src_i,
    input  logic [31:0]       dst_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [31:0]       ram_addr_o,
    output logic              ram_en_o,
    output logic [3:0]        ram_we_o,
    output logic [31:0]       ram_din_o,
    input  logic [31:0]       ram_dout_i
);

    copy_state_e       state_q, state_d;
    logic [ADDR_W-1:0] src_q,   src_d;
    logic [ADDR_W-1:0] dst_q,   dst_d;
    logic [LEN_W-1:0]  cnt_q,   cnt_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              err_q,   err_d;

    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic              errp_q,  errp_d;
    logic              en_q,    en_d;
    logic [WE_W-1:0]   we_q,    we_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    src_d = src_i;
                    dst_d = dst_i;
                    cnt_d = len_i;
                    if (!is_aligned(src_i) || !is_aligned(dst_i)) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (len_i == LEN_W'(0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                state_d = LAT;
            end
            LAT: begin
                data_d  = ram_dout_i;
                state_d = WR;
            end
            WR: begin
                src_d = src_q + WORD_BYTES;
                dst_d = dst_q + WORD_BYTES;
                cnt_d = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    state_d = DONE;
                end else begin
                    state_d = RD;
                end
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with it.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        errp_d = 1'b0;
        en_d   = 1'b0;
        we_d   = WE_NONE;
        addr_d = '0;

        case (state_d)
            RD: begin
                busy_d = 1'b1;
                en_d   = 1'b1;
                addr_d = src_d;
            end
            LAT: begin
                busy_d = 1'b1;
            end
            WR: begin
                busy_d = 1'b1;
                en_d   = 1'b1;
                we_d   = WE_FULL;
                addr_d = dst_d;
            end
            DONE: begin
                done_d = 1'b1;
                errp_d = err_d;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            errp_q  <= 1'b0;
            en_q    <= 1'b0;
            we_q    <= WE_NONE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            errp_q  <= errp_d;
            en_q    <= en_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = errp_q;
    assign ram_en_o   = en_q;
    assign ram_we_o   = we_q;
    assign ram_addr_o = addr_q;
    // Write data is the captured word; it simply holds between writes.
    assign ram_din_o  = data_q;

endmodule : ram_copy_engine

// File: tb/tb_ram_copy_engine.sv
// Bench for ram_copy_engine: behavioural word RAM plus an array-based copy model.
module tb_ram_copy_engine;

    localparam int unsigned LEN_W     = 16;
    localparam int unsigned MEM_WORDS = 1024;

    logic              clk;
    logic              rstn_i;
    logic              start_i;
    logic [31:0]       src_i;
    logic [31:0]       dst_i;
    logic [LEN_W-1:0]  len_i;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic [31:0]       ram_addr_o;
    logic              ram_en_o;
    logic [3:0]        ram_we_o;
    logic [31:0]       ram_din_o;
    logic [31:0]       ram_dout_i;

    logic [31:0] mem     [0:MEM_WORDS-1];
    logic [31:0] ref_mem [0:MEM_WORDS-1];
    int          n_vec;
    int          n_err;
    int          wr_count;

    ram_copy_engine #(.LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rstn_i     (rstn_i),
        .start_i    (start_i),
        .src_i      (src_i),
        .dst_i      (dst_i),
        .len_i      (len_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .ram_addr_o (ram_addr_o),
        .ram_en_o   (ram_en_o),
        .ram_we_o   (ram_we_o),
        .ram_din_o  (ram_din_o),
        .ram_dout_i (ram_dout_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with byte enables and one-cycle registered read (4 KiB, address aliases).
    always @(posedge clk) begin
        if (ram_en_o) begin
            if (ram_we_o != 4'h0) begin
                for (int b = 0; b < 4; b++)
                    if (ram_we_o[b]) mem[ram_addr_o[11:2]][8*b +: 8] = ram_din_o[8*b +: 8];
                wr_count = wr_count + 1;
            end else begin
                ram_dout_i <= mem[ram_addr_o[11:2]];
            end
        end
    end

    task automatic fill_random();
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        wr_count = 0;
    endtask

    // Reference: copy ascending, one word at a time, 32-bit wrapping addresses.
    task automatic model_copy(input logic [31:0] src, input logic [31:0] dst, input int len);
        logic [31:0] s;
        logic [31:0] d;
        s = src;
        d = dst;
        for (int i = 0; i < len; i++) begin
            ref_mem[d[11:2]] = ref_mem[s[11:2]];
            s = s + 32'd4;
            d = d + 32'd4;
        end
    endtask

    function automatic int mem_diff(output int first);
        int n;
        n = 0;
        first = -1;
        for (int i = 0; i < MEM_WORDS; i++) begin
            if (mem[i] !== ref_mem[i]) begin
                if (first < 0) first = i;
                n++;
            end
        end
        return n;
    endfunction

    task automatic start_copy(input logic [31:0] src, input logic [31:0] dst,
                              input logic [LEN_W-1:0] len);
        @(negedge clk);
        src_i   = src;
        dst_i   = dst;
        len_i   = len;
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
    endtask

    // Observe cycles 1.. after the start edge until done; optionally re-pulse start mid-copy.
    task automatic wait_done(input int budget, input int restart_cyc, output int done_cyc,
                             output int busy_cnt, output int en_cnt, output logic err_seen);
        done_cyc = -1;
        busy_cnt = 0;
        en_cnt   = 0;
        err_seen = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (restart_cyc > 0 && k == restart_cyc) begin
                dst_i   = 32'h300;
                start_i = 1'b1;
            end
            if (restart_cyc > 0 && k == restart_cyc + 1) start_i = 1'b0;
            if (busy_o) busy_cnt++;
            if (ram_en_o) en_cnt++;
            if (done_o) begin
                done_cyc = k;
                err_seen = err_o;
                break;
            end
        end
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        rstn_i  = 1'b0;
        start_i = 1'b0;
        src_i   = '0;
        dst_i   = '0;
        len_i   = '0;
        wr_count = 0;
        repeat (3) @(negedge clk);
        n_vec++; if (busy_o !== 1'b0)      begin n_err++; $display("FAIL reset_busy got %0b exp 0", busy_o); end
        n_vec++; if (done_o !== 1'b0)      begin n_err++; $display("FAIL reset_done got %0b exp 0", done_o); end
        n_vec++; if (err_o !== 1'b0)       begin n_err++; $display("FAIL reset_err got %0b exp 0", err_o); end
        n_vec++; if (ram_en_o !== 1'b0)    begin n_err++; $display("FAIL reset_en got %0b exp 0", ram_en_o); end
        n_vec++; if (ram_we_o !== 4'h0)    begin n_err++; $display("FAIL reset_we got %h exp 0", ram_we_o); end
        n_vec++; if (ram_addr_o !== 32'h0) begin n_err++; $display("FAIL reset_addr got %h exp 0", ram_addr_o); end
        n_vec++; if (ram_din_o !== 32'h0)  begin n_err++; $display("FAIL reset_din got %h exp 0", ram_din_o); end
        rstn_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int dc, bc, ec, nd, fi;
        logic er;
        fill_random();
        for (int i = 0; i < 4; i++) begin
            mem[64+i]     = 32'hA0 + 32'(i);
            ref_mem[64+i] = 32'hA0 + 32'(i);
        end
        model_copy(32'h100, 32'h200, 4);
        start_copy(32'h100, 32'h200, 16'd4);
        wait_done(40, 0, dc, bc, ec, er);
        n_vec++; if (dc != 13)   begin n_err++; $display("FAIL basic_done_cycle got %0d exp 13", dc); end
        n_vec++; if (bc != 12)   begin n_err++; $display("FAIL basic_busy_cycles got %0d exp 12", bc); end
        n_vec++; if (er !== 1'b0) begin n_err++; $display("FAIL basic_err got %0b exp 0", er); end
        n_vec++; if (ec != 8)    begin n_err++; $display("FAIL basic_en_cycles got %0d exp 8", ec); end
        n_vec++; if (mem[128+3] !== 32'hA3) begin n_err++; $display("FAIL basic_last_word got %h exp a3", mem[131]); end
        nd = mem_diff(fi);
        n_vec++; if (nd != 0) begin n_err++; $display("FAIL basic_mem got %0d bad words (first %0d) exp 0", nd, fi); end
        @(negedge clk);
        n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL basic_done_width got %0b exp 0", done_o); end
    endtask

    task automatic test_len0();
        int dc, bc, ec;
        logic er;
        wr_count = 0;
        start_copy(32'h100, 32'h200, 16'd0);
        wait_done(10, 0, dc, bc, ec, er);
        n_vec++; if (dc != 1)     begin n_err++; $display("FAIL len0_done_cycle got %0d exp 1", dc); end
        n_vec++; if (er !== 1'b0) begin n_err++; $display("FAIL len0_err got %0b exp 0", er); end
        n_vec++; if (ec != 0 || bc != 0 || wr_count != 0)
            begin n_err++; $display("FAIL len0_ram_access got en=%0d busy=%0d wr=%0d exp 0", ec, bc, wr_count); end
    endtask

    task automatic test_misaligned();
        int dc, bc, ec;
        logic er;
        logic [31:0] srcs [2];
        logic [31:0] dsts [2];
        srcs[0] = 32'h102; dsts[0] = 32'h200;
        srcs[1] = 32'h100; dsts[1] = 32'h201;
        for (int c = 0; c < 2; c++) begin
            wr_count = 0;
            start_copy(srcs[c], dsts[c], 16'd4);
            wait_done(10, 0, dc, bc, ec, er);
            n_vec++; if (dc != 1)     begin n_err++; $display("FAIL misalign%0d_done_cycle got %0d exp 1", c, dc); end
            n_vec++; if (er !== 1'b1) begin n_err++; $display("FAIL misalign%0d_err got %0b exp 1", c, er); end
            n_vec++; if (ec != 0 || bc != 0 || wr_count != 0)
                begin n_err++; $display("FAIL misalign%0d_ram_access got en=%0d busy=%0d wr=%0d exp 0", c, ec, bc, wr_count); end
            @(negedge clk);
            n_vec++; if (err_o !== 1'b0 || done_o !== 1'b0)
                begin n_err++; $display("FAIL misalign%0d_pulse_width got err=%0b done=%0b exp 0", c, err_o, done_o); end
        end
    endtask

    task automatic test_start_ignored();
        int dc, bc, ec, nd, fi, extra;
        logic er;
        fill_random();
        model_copy(32'h100, 32'h200, 4);
        start_copy(32'h100, 32'h200, 16'd4);
        wait_done(40, 5, dc, bc, ec, er);
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done_o || busy_o) extra++;
        end
        n_vec++; if (dc != 13)  begin n_err++; $display("FAIL restart_done_cycle got %0d exp 13", dc); end
        n_vec++; if (extra != 0) begin n_err++; $display("FAIL restart_extra_activity got %0d exp 0", extra); end
        nd = mem_diff(fi);
        n_vec++; if (nd != 0 || wr_count != 4)
            begin n_err++; $display("FAIL restart_mem got %0d bad words (first %0d) wr=%0d exp 0/4", nd, fi, wr_count); end
    endtask

    task automatic test_reset_mid();
        int dc, bc, ec, nd, fi, seen_done;
        logic er;
        fill_random();
        model_copy(32'h100, 32'h200, 2);
        start_copy(32'h100, 32'h200, 16'd8);
        seen_done = 0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (done_o) seen_done++;
        end
        rstn_i = 1'b0;
        #1;
        n_vec++; if (busy_o !== 1'b0 || ram_en_o !== 1'b0 || ram_we_o !== 4'h0 || ram_addr_o !== 32'h0)
            begin n_err++; $display("FAIL midreset_outputs got busy=%0b en=%0b we=%h addr=%h exp 0", busy_o, ram_en_o, ram_we_o, ram_addr_o); end
        repeat (3) begin
            @(negedge clk);
            if (done_o) seen_done++;
        end
        rstn_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done_o || busy_o) seen_done++;
        end
        n_vec++; if (seen_done != 0) begin n_err++; $display("FAIL midreset_done got %0d exp 0", seen_done); end
        nd = mem_diff(fi);
        n_vec++; if (nd != 0 || wr_count != 2)
            begin n_err++; $display("FAIL midreset_mem got %0d bad words (first %0d) wr=%0d exp 0/2", nd, fi, wr_count); end
        wr_count = 0;
        model_copy(32'h100, 32'h200, 8);
        start_copy(32'h100, 32'h200, 16'd8);
        wait_done(60, 0, dc, bc, ec, er);
        n_vec++; if (dc != 25) begin n_err++; $display("FAIL midreset_rerun_cycle got %0d exp 25", dc); end
        nd = mem_diff(fi);
        n_vec++; if (nd != 0) begin n_err++; $display("FAIL midreset_rerun_mem got %0d bad words (first %0d) exp 0", nd, fi); end
    endtask

    task automatic test_overlap();
        int dc, bc, ec, nd, fi;
        logic er;
        fill_random();
        mem[64] = 32'h11; ref_mem[64] = 32'h11;
        mem[65] = 32'h22; ref_mem[65] = 32'h22;
        model_copy(32'h100, 32'h104, 2);
        start_copy(32'h100, 32'h104, 16'd2);
        wait_done(30, 0, dc, bc, ec, er);
        n_vec++; if (dc != 7) begin n_err++; $display("FAIL overlap_done_cycle got %0d exp 7", dc); end
        n_vec++; if (mem[65] !== 32'h11 || mem[66] !== 32'h11)
            begin n_err++; $display("FAIL overlap_words got %h %h exp 11 11", mem[65], mem[66]); end
        nd = mem_diff(fi);
        n_vec++; if (nd != 0) begin n_err++; $display("FAIL overlap_mem got %0d bad words (first %0d) exp 0", nd, fi); end
    endtask

    task automatic test_wrap();
        int dc, bc, ec, nd, fi;
        logic er;
        fill_random();
        model_copy(32'hFFFF_FFFC, 32'h400, 2);
        start_copy(32'hFFFF_FFFC, 32'h400, 16'd2);
        wait_done(30, 0, dc, bc, ec, er);
        n_vec++; if (dc != 7) begin n_err++; $display("FAIL wrap_done_cycle got %0d exp 7", dc); end
        n_vec++; if (mem[257] !== mem[0])
            begin n_err++; $display("FAIL wrap_second_word got %h exp %h", mem[257], mem[0]); end
        nd = mem_diff(fi);
        n_vec++; if (nd != 0) begin n_err++; $display("FAIL wrap_mem got %0d bad words (first %0d) exp 0", nd, fi); end
    endtask

    task automatic test_random();
        int dc, bc, ec, nd, fi, len;
        logic er;
        logic [31:0] s, d;
        for (int it = 0; it < 10; it++) begin
            fill_random();
            s   = $urandom & 32'hFFFF_FFFC;
            d   = $urandom & 32'hFFFF_FFFC;
            if (it < 4) d = s + 32'(4 * $urandom_range(1, 3));
            len = $urandom_range(1, 12);
            model_copy(s, d, len);
            start_copy(s, d, LEN_W'(len));
            wait_done(3 * len + 10, 0, dc, bc, ec, er);
            n_vec++; if (dc != 3 * len + 1 || bc != 3 * len || er !== 1'b0)
                begin n_err++; $display("FAIL rand%0d_timing got done=%0d busy=%0d err=%0b exp %0d/%0d/0", it, dc, bc, er, 3*len+1, 3*len); end
            nd = mem_diff(fi);
            n_vec++; if (nd != 0 || wr_count != len)
                begin n_err++; $display("FAIL rand%0d_mem got %0d bad words (first %0d) wr=%0d exp 0/%0d", it, nd, fi, wr_count, len); end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_len0();
        test_misaligned();
        test_start_ignored();
        test_reset_mid();
        test_overlap();
        test_wrap();
        test_random();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule : tb_ram_copy_engine
